// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the serial sequence detector controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_ctrl_pkg;

    // Pattern length in bits; the pattern MSB is the oldest received bit.
    localparam int SEQ_W = 4;

    // Configuration loaded by reset, so a run can start without any cfg.
    localparam logic [SEQ_W-1:0] DEFAULT_SEQ    = 4'b1001;
    localparam int               DEFAULT_TARGET = 1;

    // Fill counter tracks how many bits are in the history, saturating at
    // SEQ_W. Three bits cover 0..4.
    localparam int               FILL_W   = 3;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : seq_ctrl_pkg

// File: rtl/seq_match.sv
// Serial pattern matcher: history shift register, fill counter, comparator.
// Latency: hit is combinational on the current bit; history updates next edge.
// Backpressure: none; one bit consumed per enabled cycle.
//
// Ports:
//   clk      rising-edge clock
//   clr_n    synchronous active-low reset
//   en       shift e into history and advance the fill counter
//   clr      clear history and fill (takes priority over en)
//   e        serial data bit
//   pattern  pattern to match, MSB = oldest bit
//   hit      current bit completes the pattern with a full history
module seq_match
    import seq_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             clr,
    input  logic             e,
    input  logic [SEQ_W-1:0] pattern,
    output logic             hit
);

    // Only the newest SEQ_W-1 bits need storing: the oldest bit of a
    // SEQ_W-bit window would be shifted out before it could be compared.
    logic [SEQ_W-2:0]  history;
    logic [FILL_W-1:0] fill;

    always_ff @(posedge clk) begin
        if (!clr_n || clr) begin
            history <= '0;
            fill    <= '0;
        end else if (en) begin
            history <= {history[SEQ_W-3:0], e};
            if (fill != FILL_MAX) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

    // The window is only valid once SEQ_W-1 earlier bits have been received,
    // so stale zeros after a clear can never produce a false match.
    always_comb begin
        hit = (fill >= FILL_W'(SEQ_W - 1)) && ({history, e} == pattern);
    end

endmodule : seq_match

// File: rtl/seq_det_ctrl.sv
// Run controller for a serial sequence detector with match counting and target stop.
// Latency: Y, match_cnt and done update one edge after the matching bit is sampled.
// Backpressure: cfg_ready low while a run is active; cfg requests then stall.
//
// Ports:
//   clk        rising-edge clock
//   clr_n      synchronous active-low reset
//   cfg_valid  configuration request; accepted with cfg_ready
//   cfg_ready  high in IDLE and DONE
//   cfg_seq    pattern to detect, MSB = oldest bit
//   cfg_count  match target, 0 = run until abort
//   start      begin a run from IDLE or DONE
//   abort      end a run, keeping match_cnt
//   E          serial data bit, sampled every RUN cycle
//   Y          one-cycle registered match pulse
//   busy       high in RUN
//   done       high in DONE
//   match_cnt  saturating match count of the current/last run
module seq_det_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [SEQ_W-1:0] cfg_seq,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             start,
    input  logic             abort,
    input  logic             E,
    output logic             Y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [SEQ_W-1:0] pattern_q, pattern_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             y_q, y_d;
    logic             cfg_fire;
    logic             m_en;
    logic             m_clr;
    logic             hit;

    seq_match u_match (
        .clk     (clk),
        .clr_n   (clr_n),
        .en      (m_en),
        .clr     (m_clr),
        .e       (E),
        .pattern (pattern_q),
        .hit     (hit)
    );

    assign cfg_ready = (state_q != ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign Y         = y_q;
    assign match_cnt = cnt_q;
    assign cfg_fire  = cfg_valid && cfg_ready;

    // Saturating increment; the target compare uses this value so that the
    // match which reaches the target is the one that ends the run.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        y_d       = 1'b0;
        m_en      = 1'b0;
        m_clr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A config write in the same cycle as start takes precedence;
                // start is dropped so the run never mixes old and new config.
                if (cfg_fire) begin
                    pattern_d = cfg_seq;
                    target_d  = cfg_count;
                end else if (start) begin
                    state_d = ST_RUN;
                    m_clr   = 1'b1;
                    cnt_d   = '0;
                end
            end

            ST_RUN: begin
                m_en = 1'b1;
                // Abort suppresses a same-cycle match entirely.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (hit) begin
                    y_d   = 1'b1;
                    cnt_d = cnt_inc;
                    if ((target_q != '0) && (cnt_inc == target_q)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (cfg_fire) begin
                    pattern_d = cfg_seq;
                    target_d  = cfg_count;
                    state_d   = ST_IDLE;
                end else if (start) begin
                    state_d = ST_RUN;
                    m_clr   = 1'b1;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            pattern_q <= DEFAULT_SEQ;
            target_q  <= CNT_W'(DEFAULT_TARGET);
            cnt_q     <= '0;
            y_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
        end
    end

endmodule : seq_det_ctrl

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: directed bit streams, expected Y events queued.
// Latency: each expected Y is tagged with the cycle right after its 4th bit.
// Backpressure: n/a.
module tb_seq_det_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             clr_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [3:0]       cfg_seq;
    logic [CNT_W-1:0] cfg_count;
    logic             start;
    logic             abort;
    logic             E;
    logic             Y;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_cnt;

    seq_det_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_seq   (cfg_seq),
        .cfg_count (cfg_count),
        .start     (start),
        .abort     (abort),
        .E         (E),
        .Y         (Y),
        .busy      (busy),
        .done      (done),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int cnt;
        int dn;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every Y pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (Y === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_y: got Y=1 at cycle %0d, expected Y=0", cyc);
            end else begin
                e = q.pop_front();
                chk("y_cycle", cyc, e.cyc);
                chk("y_match_cnt", int'(match_cnt), e.cnt);
                chk("y_done", int'(done), e.dn);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one serial bit; if it completes a match, queue the expected Y.
    task automatic bit_in(input logic b, input bit exp_y, input int ecnt, input int edn);
        E = b;
        if (exp_y) q.push_back('{cyc: cyc + 1, cnt: ecnt, dn: edn});
        tick();
    endtask

    task automatic cfg(input logic [3:0] s, input logic [CNT_W-1:0] c);
        cfg_valid = 1'b1;
        cfg_seq   = s;
        cfg_count = c;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input string nm);
        chk(nm, q.size(), 0);
        q.delete();
    endtask

    initial begin
        clr_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_seq   = 4'd0;
        cfg_count = '0;
        start     = 1'b0;
        abort     = 1'b0;
        E         = 1'b0;
        tick();
        tick();
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_y", int'(Y), 0);
        chk("rst_match_cnt", int'(match_cnt), 0);
        clr_n = 1'b1;
        tick();

        // Default config 1001 / target 1.
        go();
        chk("s1_busy", int'(busy), 1);
        chk("s1_cfg_ready_run", int'(cfg_ready), 0);
        bit_in(1'b1, 0, 0, 0);
        bit_in(1'b0, 0, 0, 0);
        bit_in(1'b0, 0, 0, 0);
        bit_in(1'b1, 1, 1, 1);
        chk("s1_done", int'(done), 1);
        chk("s1_busy_after", int'(busy), 0);
        chk("s1_match_cnt", int'(match_cnt), 1);
        tick();
        drain("s1_sb_drained");

        // 1001 / target 2 with an overlapping second match.
        cfg(4'b1001, 8'd2);
        chk("s2_cfg_done_to_idle", int'(done), 0);
        chk("s2_cfg_ready", int'(cfg_ready), 1);
        go();
        bit_in(1'b1, 0, 0, 0);
        bit_in(1'b0, 0, 0, 0);
        bit_in(1'b0, 0, 0, 0);
        bit_in(1'b1, 1, 1, 0);
        bit_in(1'b0, 0, 0, 0);
        bit_in(1'b0, 0, 0, 0);
        bit_in(1'b1, 1, 2, 1);
        chk("s2_done", int'(done), 1);
        chk("s2_match_cnt", int'(match_cnt), 2);
        tick();
        drain("s2_sb_drained");

        // 0000 / unlimited; abort lands on a would-be match.
        cfg(4'b0000, 8'd0);
        go();
        bit_in(1'b0, 0, 0, 0);
        bit_in(1'b0, 0, 0, 0);
        bit_in(1'b0, 0, 0, 0);
        bit_in(1'b0, 1, 1, 0);
        bit_in(1'b0, 1, 2, 0);
        bit_in(1'b0, 1, 3, 0);
        chk("s3_busy", int'(busy), 1);
        chk("s3_match_cnt", int'(match_cnt), 3);
        abort = 1'b1;
        E     = 1'b0;
        tick();
        abort = 1'b0;
        chk("s3_abort_busy", int'(busy), 0);
        chk("s3_abort_done", int'(done), 0);
        chk("s3_abort_match_cnt", int'(match_cnt), 3);
        tick();
        drain("s3_sb_drained");

        // 1111 / target 5; abort in the cycle of the 4th one.
        cfg(4'b1111, 8'd5);
        go();
        bit_in(1'b1, 0, 0, 0);
        bit_in(1'b1, 0, 0, 0);
        bit_in(1'b1, 0, 0, 0);
        abort = 1'b1;
        E     = 1'b1;
        tick();
        abort = 1'b0;
        chk("s4_busy", int'(busy), 0);
        chk("s4_done", int'(done), 0);
        chk("s4_match_cnt", int'(match_cnt), 0);
        chk("s4_cfg_ready", int'(cfg_ready), 1);
        tick();
        drain("s4_sb_drained");

        // 1010 / unlimited; reset after two matches restores 1001 / 1.
        cfg(4'b1010, 8'd0);
        go();
        bit_in(1'b1, 0, 0, 0);
        bit_in(1'b0, 0, 0, 0);
        bit_in(1'b1, 0, 0, 0);
        bit_in(1'b0, 1, 1, 0);
        bit_in(1'b1, 0, 0, 0);
        bit_in(1'b0, 1, 2, 0);
        clr_n = 1'b0;
        E     = 1'b1;
        tick();
        clr_n = 1'b1;
        chk("s5_rst_busy", int'(busy), 0);
        chk("s5_rst_match_cnt", int'(match_cnt), 0);
        chk("s5_rst_y", int'(Y), 0);
        chk("s5_rst_cfg_ready", int'(cfg_ready), 1);
        go();
        bit_in(1'b1, 0, 0, 0);
        bit_in(1'b0, 0, 0, 0);
        bit_in(1'b0, 0, 0, 0);
        bit_in(1'b1, 1, 1, 1);
        chk("s5_default_done", int'(done), 1);
        tick();
        drain("s5_sb_drained");

        // Restart from DONE; cfg during RUN must be refused.
        go();
        chk("s6_restart_busy", int'(busy), 1);
        chk("s6_restart_match_cnt", int'(match_cnt), 0);
        cfg_valid = 1'b1;
        cfg_seq   = 4'b0000;
        cfg_count = 8'd0;
        E         = 1'b1;
        #1;
        chk("s6_cfg_ready_run", int'(cfg_ready), 0);
        tick();
        cfg_valid = 1'b0;
        bit_in(1'b0, 0, 0, 0);
        bit_in(1'b0, 0, 0, 0);
        bit_in(1'b1, 1, 1, 1);
        chk("s6_cfg_unchanged_done", int'(done), 1);

        // cfg + start together: config wins from DONE and from IDLE.
        cfg_valid = 1'b1;
        start     = 1'b1;
        cfg_seq   = 4'b0110;
        cfg_count = 8'd1;
        tick();
        chk("s6_done_cfg_start_done", int'(done), 0);
        chk("s6_done_cfg_start_busy", int'(busy), 0);
        cfg_seq   = 4'b0011;
        tick();
        cfg_valid = 1'b0;
        start     = 1'b0;
        chk("s6_idle_cfg_start_busy", int'(busy), 0);
        go();
        bit_in(1'b0, 0, 0, 0);
        bit_in(1'b0, 0, 0, 0);
        bit_in(1'b1, 0, 0, 0);
        bit_in(1'b1, 1, 1, 1);
        chk("s6_new_cfg_done", int'(done), 1);
        chk("s6_new_cfg_match_cnt", int'(match_cnt), 1);
        tick();
        tick();
        drain("s6_sb_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_det_ctrl
